// File: rtl/wb_pkg.sv
// Write-back stage shared definitions.
//   XLEN       : register-file data width
//   REG_ADDR_W : register-file address width
//   wb_src_e   : which source the write-back mux selected this cycle
package wb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_EXE  = 2'd1,
    WB_MEM  = 2'd2
  } wb_src_e;
endpackage

// File: rtl/wb_src_mux.sv
// Combinational write-back source priority mux.
// Ports:
//   reg_write_en, rd_addr, exe_result    : execute-stage request
//   from_mem, store_data_to, read_data   : memory load request (wins on conflict)
//   src, addr, data                      : selected source and its address/data;
//                                          address/data are zero when idle
module wb_src_mux
  import wb_pkg::*;
#(
  parameter int XLEN       = wb_pkg::XLEN,
  parameter int REG_ADDR_W = wb_pkg::REG_ADDR_W
) (
  input  logic                  reg_write_en,
  input  logic [XLEN-1:0]       exe_result,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  from_mem,
  input  logic [REG_ADDR_W-1:0] store_data_to,
  input  logic [XLEN-1:0]       read_data,
  output wb_src_e               src,
  output logic [REG_ADDR_W-1:0] addr,
  output logic [XLEN-1:0]       data
);

  always_comb begin
    src  = WB_NONE;
    addr = '0;
    data = '0;
    // Memory load has priority; a simultaneous execute request is silently dropped.
    if (from_mem) begin
      src  = WB_MEM;
      addr = store_data_to;
      data = read_data;
    end else if (reg_write_en) begin
      src  = WB_EXE;
      addr = rd_addr;
      data = exe_result;
    end
  end

endmodule

// File: rtl/wb_unit.sv
// Write-back unit: selects execute or memory result and registers the
// register-file write one cycle later.
// Ports:
//   clk, rst                              : clock, synchronous active-high reset
//   reg_write_en, exe_result, rd_addr     : execute write-back request
//   from_mem, store_data_to, read_data    : memory load write-back request
//   wb_done                               : a request was accepted last cycle
//   rf_we, rf_rd_addr, rf_rd_data         : register-file write port
module wb_unit
  import wb_pkg::*;
#(
  parameter int XLEN       = wb_pkg::XLEN,
  parameter int REG_ADDR_W = wb_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write_en,
  input  logic [XLEN-1:0]       exe_result,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  from_mem,
  input  logic [REG_ADDR_W-1:0] store_data_to,
  input  logic [XLEN-1:0]       read_data,
  output logic                  wb_done,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd_addr,
  output logic [XLEN-1:0]       rf_rd_data
);

  wb_src_e               sel_src;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]       sel_data;

  wb_src_mux #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_mux (
    .reg_write_en  (reg_write_en),
    .exe_result    (exe_result),
    .rd_addr       (rd_addr),
    .from_mem      (from_mem),
    .store_data_to (store_data_to),
    .read_data     (read_data),
    .src           (sel_src),
    .addr          (sel_addr),
    .data          (sel_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_done    <= 1'b0;
      rf_we      <= 1'b0;
      rf_rd_addr <= '0;
      rf_rd_data <= '0;
    end else begin
      wb_done    <= (sel_src != WB_NONE);
      // x0 is hardwired zero: the request completes but never writes.
      rf_we      <= (sel_src != WB_NONE) && (sel_addr != '0);
      rf_rd_addr <= sel_addr;
      rf_rd_data <= sel_data;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed cases followed by random traffic
// checked against a behavioural write-back model.
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_en;
  logic [31:0] exe_result;
  logic [4:0]  rd_addr;
  logic        from_mem;
  logic [4:0]  store_data_to;
  logic [31:0] read_data;
  logic        wb_done;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  wb_unit dut (
    .clk           (clk),
    .rst           (rst),
    .reg_write_en  (reg_write_en),
    .exe_result    (exe_result),
    .rd_addr       (rd_addr),
    .from_mem      (from_mem),
    .store_data_to (store_data_to),
    .read_data     (read_data),
    .wb_done       (wb_done),
    .rf_we         (rf_we),
    .rf_rd_addr    (rf_rd_addr),
    .rf_rd_data    (rf_rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, let the edge capture them, then compare the
  // registered outputs with what the write-back rules say should appear.
  task automatic step(input string tag, input logic r,
                      input logic we, input logic [4:0] ra, input logic [31:0] er,
                      input logic fm, input logic [4:0] sd, input logic [31:0] rdd);
    logic        e_done, e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    rst = r; reg_write_en = we; rd_addr = ra; exe_result = er;
    from_mem = fm; store_data_to = sd; read_data = rdd;
    e_done = 0; e_we = 0; e_addr = 0; e_data = 0;
    if (!r && fm) begin
      e_done = 1; e_addr = sd; e_data = rdd;
    end else if (!r && we) begin
      e_done = 1; e_addr = ra; e_data = er;
    end
    e_we = e_done && (e_addr != 0);
    @(posedge clk);
    #1;
    check({tag, ".wb_done"}, 32'(wb_done), 32'(e_done));
    check({tag, ".rf_we"},   32'(rf_we),   32'(e_we));
    check({tag, ".addr"},    32'(rf_rd_addr), 32'(e_addr));
    check({tag, ".data"},    rf_rd_data,   e_data);
  endtask

  initial begin
    rst = 1; reg_write_en = 0; rd_addr = 0; exe_result = 0;
    from_mem = 0; store_data_to = 0; read_data = 0;

    // Reset with an execute request held: outputs stay cleared.
    step("reset_hold", 1, 1, 5'd7, 32'hA5A5_0001, 0, 5'd0, 32'h0);
    step("reset_hold2", 1, 1, 5'd7, 32'hA5A5_0001, 0, 5'd0, 32'h0);
    // First edge with rst=0 captures the held request.
    step("post_reset", 0, 1, 5'd7, 32'hA5A5_0001, 0, 5'd0, 32'h0);

    step("exe_write",  0, 1, 5'd10, 32'h1234_5678, 0, 5'd0,  32'h0);
    step("mem_write",  0, 0, 5'd0,  32'h0,         1, 5'd12, 32'hCAFE_BABE);
    step("idle",       0, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0);
    step("conflict",   0, 1, 5'd3,  32'h1111_1111, 1, 5'd4,  32'h2222_2222);
    step("x0_exe",     0, 1, 5'd0,  32'hDEAD_BEEF, 0, 5'd9,  32'h0);
    step("x0_mem",     0, 1, 5'd6,  32'h0000_0006, 1, 5'd0,  32'hFFFF_FFFF);
    step("idle_junk",  0, 0, 5'd17, 32'h5555_AAAA, 0, 5'd22, 32'hAAAA_5555);
    // Back-to-back writes, no bubble between them.
    step("b2b_0",      0, 1, 5'd31, 32'hFFFF_FFFF, 0, 5'd0,  32'h0);
    step("b2b_1",      0, 0, 5'd0,  32'h0,         1, 5'd1,  32'h8000_0001);
    step("b2b_2",      0, 1, 5'd2,  32'h0000_0002, 0, 5'd0,  32'h0);

    // Random traffic, with occasional reset and a bias toward register 0.
    for (int i = 0; i < 300; i++) begin
      logic [4:0] ra, sd;
      ra = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      sd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      step("rand", ($urandom_range(0, 19) == 0),
           1'($urandom), ra, $urandom, 1'($urandom), sd, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
